// File: rtl/l1_cache_control_pkg.sv
// Shared types and select encodings for the L1 cache controller.
package l1_cache_types;

    typedef enum logic [1:0] {
        CHECK     = 2'd0,
        WRITEBACK = 2'd1,
        FILL      = 2'd2
    } state_e;

    localparam logic [1:0] CIN_NONE = 2'b00;
    localparam logic [1:0] CIN_WHIT = 2'b10;
    localparam logic [1:0] CIN_FILL = 2'b11;

    localparam logic [1:0] MM_NONE  = 2'b00;
    localparam logic [1:0] MM_DIRTY = 2'b01;
    localparam logic [1:0] MM_ALLOC = 2'b11;

endpackage

// File: rtl/l1_cache_control_perf_counter.sv
// Saturating event counter; holds at all-ones once reached.
module l1_perf_counter #(
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inc_i,
    output logic [PERF_CNT_W-1:0] cnt_o
);

    logic [PERF_CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/l1_cache_control.sv
// L1 cache control FSM: hit check, dirty writeback, line fill.
// Optional performance counters enabled by L1_CACHE_PERF_CNT_EN.
module l1_cache_control
    import l1_cache_types::*;
#(
    parameter int unsigned PERF_CNT_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_read,
    input  logic                  mem_write,
    output logic                  mem_resp,
    input  logic                  hit,
    input  logic                  lru_valid_dirty,
    output logic                  addr_sel,
    output logic [1:0]            cache_in_sel,
    output logic [1:0]            metamux_sel,
    output logic                  lru_itf_load,
    output logic                  pmem_read,
    output logic                  pmem_write,
    input  logic                  pmem_resp,
    output logic [PERF_CNT_W-1:0] hit_count,
    output logic [PERF_CNT_W-1:0] miss_count,
    output logic [PERF_CNT_W-1:0] wb_count
);

    state_e state_q, state_d;
    logic   req;

    assign req = mem_read | mem_write;

    always_ff @(posedge clk) begin
        if (rst) state_q <= CHECK;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            CHECK:     if (req && !hit) state_d = lru_valid_dirty ? WRITEBACK : FILL;
            WRITEBACK: if (pmem_resp)   state_d = FILL;
            FILL:      if (pmem_resp)   state_d = CHECK;
            default:                    state_d = CHECK;
        endcase
    end

    always_comb begin
        mem_resp     = 1'b0;
        addr_sel     = 1'b0;
        cache_in_sel = CIN_NONE;
        metamux_sel  = MM_NONE;
        lru_itf_load = 1'b0;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
        case (state_q)
            CHECK: begin
                if (req && hit) begin
                    mem_resp     = 1'b1;
                    lru_itf_load = 1'b1;
                    // A simultaneous read+write is handled as a write
                    if (mem_write) begin
                        cache_in_sel = CIN_WHIT;
                        metamux_sel  = MM_DIRTY;
                    end
                end
            end
            WRITEBACK: begin
                addr_sel   = 1'b1;
                pmem_write = 1'b1;
            end
            FILL: begin
                pmem_read = 1'b1;
                if (pmem_resp) begin
                    cache_in_sel = CIN_FILL;
                    metamux_sel  = MM_ALLOC;
                end
            end
            default: ;
        endcase
    end

`ifdef L1_CACHE_PERF_CNT_EN
    logic refill_q, refill_d;
    logic hit_ev, miss_ev, wb_ev;

    // Marks the re-check cycle after a fill so its hit is not counted
    assign refill_d = (state_q == FILL) && pmem_resp;

    always_ff @(posedge clk) begin
        if (rst) refill_q <= 1'b0;
        else     refill_q <= refill_d;
    end

    assign hit_ev  = (state_q == CHECK) && req && hit && !refill_q;
    assign miss_ev = (state_q == CHECK) && req && !hit;
    assign wb_ev   = miss_ev && lru_valid_dirty;

    l1_perf_counter #(.PERF_CNT_W(PERF_CNT_W)) u_hit_cnt (
        .clk(clk), .rst(rst), .inc_i(hit_ev), .cnt_o(hit_count)
    );
    l1_perf_counter #(.PERF_CNT_W(PERF_CNT_W)) u_miss_cnt (
        .clk(clk), .rst(rst), .inc_i(miss_ev), .cnt_o(miss_count)
    );
    l1_perf_counter #(.PERF_CNT_W(PERF_CNT_W)) u_wb_cnt (
        .clk(clk), .rst(rst), .inc_i(wb_ev), .cnt_o(wb_count)
    );
`else
    assign hit_count  = '0;
    assign miss_count = '0;
    assign wb_count   = '0;
`endif

    a_rd_wr_exclusive: assert property (@(posedge clk) disable iff (rst)
        !(mem_read && mem_write));

endmodule

// File: doc/l1_cache_control.md
Name: l1_cache_control

Overview:
- Moore/Mealy control FSM that sequences the L1 cache datapath: hit/miss check, dirty-victim writeback, line fill and metadata/LRU updates.
- Sits between the CPU-side memory port, the cache datapath (hit, lru_valid_dirty in; addr_sel, cache_in_sel, metamux_sel, lru_itf_load out) and the cacheline adaptor (pmem_read/pmem_write/pmem_resp).
- One instance per L1 (I-cache and D-cache).

Parameters:
- PERF_CNT_W, 32, width of the optional performance counters.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp.
- mem_resp  out  1  one-cycle completion pulse to CPU.
- hit  in  1  datapath: tag match in some valid way.
- lru_valid_dirty  in  1  datapath: LRU victim is valid and dirty.
- addr_sel  out  1  0 = CPU address, 1 = victim writeback address.
- cache_in_sel  out  2  00 = no write, 10 = write-hit byte-enabled write, 11 = fill full line from pmem into LRU way.
- metamux_sel  out  2  00 = no meta load, 01 = set dirty on hit way, 11 = set valid, clear dirty, load tag into LRU way.
- lru_itf_load  out  1  update PLRU bits for the hit way.
- pmem_read  out  1  cacheline adaptor read request.
- pmem_write  out  1  cacheline adaptor write request.
- pmem_resp  in  1  cacheline adaptor done.
- hit_count, miss_count, wb_count  out  PERF_CNT_W each  performance counters (see Optional Feature).

Behaviour:
- States: CHECK, WRITEBACK, FILL. Reset and idle state is CHECK.
- Default outputs every cycle: all outputs 0, addr_sel = 0. Reset drives state to CHECK; all outputs are combinationally 0 in the cycle after reset.
- CHECK, no request: all outputs default; stay in CHECK.
- CHECK, request && hit:
  - Same cycle: mem_resp = 1, lru_itf_load = 1.
  - If mem_write, also cache_in_sel = 10 and metamux_sel = 01.
  - Stay in CHECK. Hit latency is 1 cycle.
- CHECK, request && !hit: no mem_resp. Next state is WRITEBACK if lru_valid_dirty, else FILL.
- WRITEBACK:
  - Outputs: addr_sel = 1, pmem_write = 1, held until pmem_resp.
  - On pmem_resp, go to FILL.
- FILL:
  - Outputs: addr_sel = 0, pmem_read = 1, held until pmem_resp.
  - In the pmem_resp cycle: cache_in_sel = 11, metamux_sel = 11. Next state is CHECK.
- After a fill, CHECK re-evaluates and hits. A write miss therefore completes as a write hit on the re-check, which sets dirty.
- Miss latency: 1 + (WB pmem latency) + (fill pmem latency) + 1 cycles to mem_resp.
- mem_read && mem_write together: treated as a write. Illegal per CPU protocol; the assertion flags it.
- Request dropped mid-miss: WRITEBACK and FILL still complete (the line is installed). CHECK then idles with no mem_resp.
- pmem_resp while in CHECK: ignored.
- pmem_read and pmem_write are never both 1.
- rst mid-WRITEBACK or mid-FILL: returns to CHECK next edge and pmem strobes drop. The adaptor is reset by the same rst.
- mem_resp never asserts in WRITEBACK or FILL.

Optional Feature:
- Macro: L1_CACHE_PERF_CNT_EN.
- Defined:
  - hit_count increments on each CHECK hit that raises mem_resp, excluding the post-fill re-check hit.
  - miss_count increments on each CHECK miss.
  - wb_count increments on entry to WRITEBACK.
  - All counters saturate at all-ones and reset to 0.
- Undefined: the counter logic is not compiled and the three ports are tied to 0.

Decomposition:
- Package l1_cache_types holds:
  - state enum (CHECK, WRITEBACK, FILL);
  - cache_in_sel constants: CIN_NONE = 00, CIN_WHIT = 10, CIN_FILL = 11;
  - metamux_sel constants: MM_NONE = 00, MM_DIRTY = 01, MM_ALLOC = 11.
- One natural sub-module: l1_perf_counter, a saturating PERF_CNT_W counter with inc/rst, instantiated three times under the macro.

Test Plan:
- Read hit: mem_read = 1, hit = 1 -> same cycle mem_resp = 1, lru_itf_load = 1, cache_in_sel = 00, metamux_sel = 00; state stays CHECK.
- Write hit: mem_write = 1, hit = 1 -> mem_resp = 1, cache_in_sel = 10, metamux_sel = 01, lru_itf_load = 1.
- Clean read miss: hit = 0, lru_valid_dirty = 0, pmem_resp after 3 cycles.
  - Required: FILL with pmem_read = 1 for 3 cycles.
  - In the resp cycle cache_in_sel = 11, metamux_sel = 11.
  - Next cycle hit = 1 -> mem_resp = 1. Total 5 cycles.
- Dirty write miss: lru_valid_dirty = 1.
  - Required: WRITEBACK with addr_sel = 1, pmem_write = 1 until pmem_resp, then FILL, then CHECK write-hit outputs 10/01.
  - With the macro: wb_count = 1, miss_count = 1, hit_count = 0.
- Reset in FILL: rst = 1 for one cycle mid-FILL -> next cycle pmem_read = 0, state CHECK, all outputs 0.
- Saturation: with the macro and PERF_CNT_W = 4, 20 read hits -> hit_count = 4'hF.
